instr_queue_issue: RTL
======================

Name: instr_queue_issue

Overview:
- Consumer end of the control unit's instruction-queue push interface.
- Buffers pushed entries in a FIFO, then expands each entry's copy count into individual issue beats, one per cycle, toward the execution backend.
- Each beat carries per-copy cache and main-memory addresses: base + k*delta.
- Retires the program-end marker and pulses program_complete to the host.

Parameters:
- LOG_SUPERSCALAR_WIDTH, 3: copy count field is LOG_SUPERSCALAR_WIDTH+1 bits; max copies per entry = 2^LOG_SUPERSCALAR_WIDTH.
- LOG_DEPTH, 3: FIFO depth = 2^LOG_DEPTH entries (min 2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- queue_we  in  1  push strobe, one entry per high cycle
- queue_instr_type  in  2  0=LOAD_STORE, 1=RAM, 2=ARITHMETIC, 3=PROG_END
- queue_copy_count  in  LOG_SUPERSCALAR_WIDTH+1  copies to issue
- queue_arith_instr  in  9  arithmetic payload
- queue_ram_instr  in  3  {is_write, cache_slot}
- queue_ld_st_instr  in  7  {is_load, cache_slot, regfile_reg, zero_flag, skip_flag}
- cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr  in  18 each  base addresses and per-copy deltas
- instr_queue_stall_push  out  1  producer must not start a new push
- issue_valid  out  1  beat present
- issue_ready  in  1  backend accepts beat
- issue_instr_type  out  2
- issue_arith_instr  out  9
- issue_ram_instr  out  3
- issue_ld_st_instr  out  7
- issue_cache_addr, issue_main_mem_addr  out  18 each
- issue_copy_index  out  LOG_SUPERSCALAR_WIDTH  k of current beat
- issue_last  out  1  final copy of entry
- program_complete  out  1  one-cycle pulse
- queue_overflow  out  1  sticky error

Behaviour:
- Reset (async, any cycle, mid-expansion included):
  - FIFO empty; copy index k=0.
  - issue_valid=0, program_complete=0, queue_overflow=0, instr_queue_stall_push=0.
  - All issue payload outputs are 0.
  - Operation resumes on the first clk edge after reset deasserts.
- FIFO storage and occupancy:
  - Register-based storage; read and write pointers LOG_DEPTH bits, wrapping.
  - Occupancy count is LOG_DEPTH+1 bits.
- Stall:
  - instr_queue_stall_push = (count >= DEPTH-1), combinational from registered count.
  - The producer samples stall one cycle before asserting queue_we, so one slot of slack is required.
- Push:
  - queue_we=1 with count<DEPTH: all inputs written at the posedge.
  - A push while count==DEPTH with no pop in that cycle is dropped and sets queue_overflow (sticky until reset).
  - A push and a pop in the same cycle while full are both accepted.
- Latency: an entry pushed at edge N is visible at head after edge N; issue_valid can be high in the following cycle. No bypass.
- Copy count normalization:
  - eff = copy_count clamped to 2^LOG_SUPERSCALAR_WIDTH.
  - copy_count 0 is treated as 1.
- Head entry of type 0–2 (issue):
  - issue_valid=1; payload comes combinationally from the head entry.
  - issue_cache_addr = cache_addr + k*d_cache_addr, mod 2^18.
  - issue_main_mem_addr = main_mem_addr + k*d_main_mem_addr, mod 2^18.
  - The k*d products are maintained as running sums: add delta on each accepted beat, clear on pop. No multiplier.
  - issue_last = (k == eff-1).
  - On issue_valid & issue_ready: if issue_last, pop the entry and set k=0; else k=k+1.
  - Payload holds stable while valid & !ready.
- Head entry of type 3 (PROG_END):
  - issue_valid=0; the entry is popped in the cycle it reaches head.
  - program_complete=1 for exactly that cycle, registered so it asserts the cycle after the marker reaches head.
  - Issue is strictly in order, so all prior beats have already handed off.
- Empty FIFO: issue_valid=0; k is held.

Test Plan:
- Push RAM entry, count=3, cache_addr=100, d_cache=4, main=1000, d_main=16, issue_ready=1 → 3 beats on consecutive cycles with cache 100/104/108, main 1000/1016/1032, index 0/1/2, issue_last on the third; FIFO then empty.
- Push LOAD_STORE count=8, issue_ready toggling 1,0,1,0… → 8 beats; payload stable during ready=0 cycles; k never skips; d_cache=0x3FFFF wraps addresses mod 2^18 (base 5 → 5, 4, 3, …).
- Push ARITHMETIC count=0, then count=12 → 1 beat, then 8 beats.
- Issue_ready=0, push 8 entries → stall asserts once count reaches 7; a 9th push sets queue_overflow with count still 8; one pop plus push in the same cycle keeps count at 8 with no overflow.
- Push two ARITHMETIC entries, count=2 each, then PROG_END, issue_ready=1 → 4 beats, then a single program_complete pulse, never before the last beat handshake.
- Assert reset mid-expansion (k=2 of 5) → outputs zero immediately without a clock edge; after release, stale entries are gone and a new push issues from k=0.

Source files
------------

// File: rtl/instr_queue_issue.sv
// Instruction-queue consumer: buffers pushed entries in a register FIFO and
// expands each entry's copy count into one issue beat per cycle, carrying
// per-copy addresses base + k*delta. Retires the program-end marker with a
// one-cycle program_complete pulse.
module instr_queue_issue #(
   parameter int unsigned LOG_SUPERSCALAR_WIDTH = 3,
   parameter int unsigned LOG_DEPTH             = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             queue_we,
   input  logic [1:0]                       queue_instr_type,
   input  logic [LOG_SUPERSCALAR_WIDTH:0]   queue_copy_count,
   input  logic [8:0]                       queue_arith_instr,
   input  logic [2:0]                       queue_ram_instr,
   input  logic [6:0]                       queue_ld_st_instr,
   input  logic [17:0]                      cache_addr,
   input  logic [17:0]                      main_mem_addr,
   input  logic [17:0]                      d_cache_addr,
   input  logic [17:0]                      d_main_mem_addr,
   output logic                             instr_queue_stall_push,
   output logic                             issue_valid,
   input  logic                             issue_ready,
   output logic [1:0]                       issue_instr_type,
   output logic [8:0]                       issue_arith_instr,
   output logic [2:0]                       issue_ram_instr,
   output logic [6:0]                       issue_ld_st_instr,
   output logic [17:0]                      issue_cache_addr,
   output logic [17:0]                      issue_main_mem_addr,
   output logic [LOG_SUPERSCALAR_WIDTH-1:0] issue_copy_index,
   output logic                             issue_last,
   output logic                             program_complete,
   output logic                             queue_overflow
);

   localparam int unsigned DEPTH = 1 << LOG_DEPTH;
   localparam int unsigned KW    = LOG_SUPERSCALAR_WIDTH;
   localparam int unsigned CCW   = LOG_SUPERSCALAR_WIDTH + 1;
   localparam int unsigned MAXC  = 1 << LOG_SUPERSCALAR_WIDTH;
   localparam int unsigned OW    = LOG_DEPTH + 1;
   localparam int unsigned AW    = 18;

   localparam logic [OW-1:0]  DEPTH_C      = OW'(DEPTH);
   localparam logic [OW-1:0]  STALL_C      = OW'(DEPTH - 1);
   localparam logic [CCW-1:0] MAXC_C       = CCW'(MAXC);
   localparam logic [KW-1:0]  MAX_IDX_C    = KW'(MAXC - 1);
   localparam logic [1:0]     T_PROG_END   = 2'd3;

   typedef struct packed {
      logic [1:0]     instr_type;
      logic [CCW-1:0] copy_count;
      logic [8:0]     arith_instr;
      logic [2:0]     ram_instr;
      logic [6:0]     ld_st_instr;
      logic [AW-1:0]  cache_addr;
      logic [AW-1:0]  main_mem_addr;
      logic [AW-1:0]  d_cache_addr;
      logic [AW-1:0]  d_main_mem_addr;
   } entry_t;

   entry_t               mem [DEPTH];
   entry_t               head;
   entry_t               wr_entry;
   logic [LOG_DEPTH-1:0] rd_ptr;
   logic [LOG_DEPTH-1:0] wr_ptr;
   logic [OW-1:0]        count;
   logic [KW-1:0]        k;
   logic [AW-1:0]        acc_cache;
   logic [AW-1:0]        acc_main;

   logic                 not_empty;
   logic                 full;
   logic                 head_is_end;
   logic [KW-1:0]        last_idx;
   logic                 last_c;
   logic                 beat;
   logic                 pop;
   logic                 push;

   // Pack the producer's fields into one FIFO entry.
   always_comb begin
      wr_entry                 = '0;
      wr_entry.instr_type      = queue_instr_type;
      wr_entry.copy_count      = queue_copy_count;
      wr_entry.arith_instr     = queue_arith_instr;
      wr_entry.ram_instr       = queue_ram_instr;
      wr_entry.ld_st_instr     = queue_ld_st_instr;
      wr_entry.cache_addr      = cache_addr;
      wr_entry.main_mem_addr   = main_mem_addr;
      wr_entry.d_cache_addr    = d_cache_addr;
      wr_entry.d_main_mem_addr = d_main_mem_addr;
   end

   // Head decode, copy-count normalization, handshake and FIFO control.
   always_comb begin
      head        = mem[rd_ptr];
      not_empty   = (count != '0);
      full        = (count == DEPTH_C);
      head_is_end = not_empty && (head.instr_type == T_PROG_END);
      issue_valid = not_empty && !head_is_end;

      // copy_count 0 behaves as 1; anything above the superscalar width clamps
      last_idx = '0;
      if (head.copy_count == '0)
         last_idx = '0;
      else if (head.copy_count >= MAXC_C)
         last_idx = MAX_IDX_C;
      else
         last_idx = KW'(head.copy_count - CCW'(1));

      last_c = (k == last_idx);
      beat   = issue_valid && issue_ready;
      pop    = head_is_end || (beat && last_c);
      push   = queue_we && (!full || pop);

      instr_queue_stall_push = (count >= STALL_C);
   end

   // Issue payload, forced to zero whenever no beat is presented.
   always_comb begin
      issue_instr_type    = '0;
      issue_arith_instr   = '0;
      issue_ram_instr     = '0;
      issue_ld_st_instr   = '0;
      issue_cache_addr    = '0;
      issue_main_mem_addr = '0;
      issue_copy_index    = '0;
      issue_last          = 1'b0;
      if (issue_valid) begin
         issue_instr_type    = head.instr_type;
         issue_arith_instr   = head.arith_instr;
         issue_ram_instr     = head.ram_instr;
         issue_ld_st_instr   = head.ld_st_instr;
         issue_cache_addr    = head.cache_addr + acc_cache;
         issue_main_mem_addr = head.main_mem_addr + acc_main;
         issue_copy_index    = k;
         issue_last          = last_c;
      end
   end

   // Entry storage; contents are meaningless outside the occupied window.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   // Pointers, occupancy, copy index, running k*delta sums and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr           <= '0;
         wr_ptr           <= '0;
         count            <= '0;
         k                <= '0;
         acc_cache        <= '0;
         acc_main         <= '0;
         program_complete <= 1'b0;
         queue_overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
         if (pop)  rd_ptr <= rd_ptr + LOG_DEPTH'(1);

         case ({push, pop})
            2'b10:   count <= count + OW'(1);
            2'b01:   count <= count - OW'(1);
            default: count <= count;
         endcase

         if (pop) begin
            k         <= '0;
            acc_cache <= '0;
            acc_main  <= '0;
         end else if (beat) begin
            k         <= k + KW'(1);
            acc_cache <= acc_cache + head.d_cache_addr;
            acc_main  <= acc_main + head.d_main_mem_addr;
         end

         program_complete <= head_is_end;
         queue_overflow   <= queue_overflow || (queue_we && full && !pop);
      end
   end

endmodule
